// File: rtl/wb_uart_pkg.sv
// Shared constants and FSM encoding for the wb_uart scheduler.
package wb_uart_pkg;

  // wb_uart register offsets from the base address
  localparam logic [3:0] OFF_DATA      = 4'h0;
  localparam logic [3:0] OFF_RX_STATUS = 4'h4;
  localparam logic [3:0] OFF_TX_STATUS = 4'h8;

  // "ready" flag position inside both status registers
  localparam int ST_BIT = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_POLL,
    S_TX_WR,
    S_RX_POLL,
    S_RX_RD,
    S_GAP
  } sched_state_e;

endpackage

// File: rtl/wb_uart_sched_if.sv
// Wishbone master-side bundle between the scheduler and the wb_uart slave.
interface wb_uart_sched_if #(
  parameter int ADR_W = 32
);
  logic             wbm_cyc_o;
  logic             wbm_stb_o;
  logic             wbm_we_o;
  logic [ADR_W-1:0] wbm_adr_o;
  logic [31:0]      wbm_dat_o;
  logic [3:0]       wbm_sel_o;
  logic [31:0]      wbm_dat_i;
  logic             wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/wb_uart_rr_arb.sv
// Round-robin arbiter with packet lock: a grant taken stays until freed,
// and freeing moves the search start to the requester after the winner.
module wb_uart_rr_arb #(
  parameter  int N_REQ = 2,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             take,
  input  logic             free,
  output logic             locked,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N_REQ-1:0] grant_oh
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] cand;
  logic             found;

  // first valid requester at or after the pointer, wrapping
  always_comb begin
    pick  = ptr;
    cand  = ptr;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % N_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // lock on take, release and advance the pointer on free
  always_ff @(posedge clk) begin
    if (rst) begin
      locked    <= 1'b0;
      ptr       <= '0;
      grant_idx <= '0;
    end else if (free) begin
      locked <= 1'b0;
      ptr    <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end else if (take && !locked && found) begin
      locked    <= 1'b1;
      grant_idx <= pick;
    end
  end

  assign grant_oh = locked ? (N_REQ'(1) << grant_idx) : '0;

endmodule

// File: rtl/wb_uart_sched.sv
// Wishbone master that feeds N byte streams into one wb_uart and drains
// its receiver into a single valid/ready stream, polling status in hardware.
module wb_uart_sched
  import wb_uart_pkg::*;
#(
  parameter  int               N_REQ     = 2,
  parameter  int               ADR_W     = 32,
  parameter  logic [ADR_W-1:0] BASE_ADDR = '0,
  parameter  int               POLL_GAP  = 16,
  localparam int               IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  wb_uart_sched_if.master      wbm,
  input  logic [N_REQ-1:0]     req_valid_i,
  input  logic [8*N_REQ-1:0]   req_data_i,
  input  logic [N_REQ-1:0]     req_last_i,
  output logic [N_REQ-1:0]     req_ready_o,
  output logic                 rx_valid_o,
  output logic [7:0]           rx_data_o,
  input  logic                 rx_ready_i,
  input  logic                 rx_en_i,
  output logic                 busy_o
);

  localparam int GAP_W = $clog2(POLL_GAP + 1);

  sched_state_e state, state_n;

  logic             cyc_q, stb_q, we_q;
  logic [ADR_W-1:0] adr_q;
  logic [31:0]      dat_q;
  logic [3:0]       sel_q;

  logic [7:0]       tx_byte;
  logic             tx_last;
  logic             tx_wrote;
  logic [GAP_W-1:0] gap_cnt;

  logic             locked;
  logic [IDX_W-1:0] grant_idx;
  logic [N_REQ-1:0] grant_oh;

  logic             issue, op_we;
  logic [3:0]       op_off;
  logic             arb_take, arb_free;
  logic             tx_done, rx_done;
  logic             bus_done, st_bit, rx_slot, tx_want;
  logic             unused_dat;

  assign bus_done   = cyc_q && wbm.wbm_ack_i;
  assign st_bit     = wbm.wbm_dat_i[ST_BIT];
  assign rx_slot    = rx_en_i && !rx_valid_o;
  // once locked only the owner of the grant can start a TX round
  assign tx_want    = locked ? req_valid_i[grant_idx] : |req_valid_i;
  assign unused_dat = ^wbm.wbm_dat_i[31:8];

  wb_uart_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .req       (req_valid_i),
    .take      (arb_take),
    .free      (arb_free),
    .locked    (locked),
    .grant_idx (grant_idx),
    .grant_oh  (grant_oh)
  );

  // next state and per-state bus request; a bus state issues while cyc is
  // low and leaves on ack, which guarantees an idle cycle between transfers
  always_comb begin
    state_n  = state;
    issue    = 1'b0;
    op_we    = 1'b0;
    op_off   = OFF_DATA;
    arb_take = 1'b0;
    arb_free = 1'b0;
    tx_done  = 1'b0;
    rx_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (tx_want) begin
          state_n  = S_TX_POLL;
          arb_take = !locked;
        end else if (rx_slot) begin
          state_n = S_RX_POLL;
        end
      end
      S_TX_POLL: begin
        op_off = OFF_TX_STATUS;
        if (!cyc_q) issue = 1'b1;
        else if (wbm.wbm_ack_i)
          state_n = st_bit ? S_TX_WR : (rx_slot ? S_RX_POLL : S_GAP);
      end
      S_TX_WR: begin
        op_we  = 1'b1;
        op_off = OFF_DATA;
        if (!cyc_q) issue = 1'b1;
        else if (wbm.wbm_ack_i) begin
          tx_done  = 1'b1;
          arb_free = tx_last;
          state_n  = rx_slot ? S_RX_POLL : S_IDLE;
        end
      end
      S_RX_POLL: begin
        op_off = OFF_RX_STATUS;
        if (!cyc_q) issue = 1'b1;
        else if (wbm.wbm_ack_i)
          state_n = st_bit ? S_RX_RD : (tx_wrote ? S_IDLE : S_GAP);
      end
      S_RX_RD: begin
        op_off = OFF_DATA;
        if (!cyc_q) issue = 1'b1;
        else if (wbm.wbm_ack_i) begin
          rx_done = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_W'(POLL_GAP - 1)) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // state, bus registers, TX capture, RX holding register and gap counter
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= S_IDLE;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      tx_byte    <= '0;
      tx_last    <= 1'b0;
      tx_wrote   <= 1'b0;
      gap_cnt    <= '0;
      rx_valid_o <= 1'b0;
      rx_data_o  <= '0;
    end else begin
      state <= state_n;
      if (issue) begin
        cyc_q <= 1'b1;
        stb_q <= 1'b1;
        we_q  <= op_we;
        adr_q <= BASE_ADDR + ADR_W'(op_off);
        dat_q <= op_we ? {24'h0, tx_byte} : 32'h0;
        sel_q <= 4'hF;
      end else if (bus_done) begin
        cyc_q <= 1'b0;
        stb_q <= 1'b0;
        we_q  <= 1'b0;
        adr_q <= '0;
        dat_q <= '0;
        sel_q <= '0;
      end
      // byte is frozen when the write is committed to; later edits are ignored
      if (state == S_TX_POLL && state_n == S_TX_WR) begin
        tx_byte <= req_data_i[8*grant_idx +: 8];
        tx_last <= req_last_i[grant_idx];
      end
      if (tx_done)               tx_wrote <= 1'b1;
      else if (state == S_IDLE)  tx_wrote <= 1'b0;
      gap_cnt <= (state == S_GAP && state_n == S_GAP) ? gap_cnt + 1'b1 : '0;
      if (rx_done) begin
        rx_valid_o <= 1'b1;
        rx_data_o  <= wbm.wbm_dat_i[7:0];
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

  assign wbm.wbm_cyc_o = cyc_q;
  assign wbm.wbm_stb_o = stb_q;
  assign wbm.wbm_we_o  = we_q;
  assign wbm.wbm_adr_o = adr_q;
  assign wbm.wbm_dat_o = dat_q;
  assign wbm.wbm_sel_o = sel_q;

  // accept pulse coincides with the DATA write ack seen by the requester
  assign req_ready_o = (tx_done && !wb_rst_i) ? grant_oh : '0;
  assign busy_o      = (state != S_IDLE);

endmodule

// File: tb/tb_wb_uart_sched.sv
// Directed bench: behavioural wb_uart slave, per-requester byte feeders,
// and TX/RX scoreboards checked with immediate assertions.
module tb_wb_uart_sched;
  import wb_uart_pkg::*;

  localparam int          N_REQ    = 2;
  localparam int          ADR_W    = 32;
  localparam int          POLL_GAP = 4;
  localparam logic [31:0] BASE     = 32'h0000_0100;

  typedef struct packed { logic [7:0] d; logic l; } byte_t;
  typedef struct packed { logic [7:0] r; logic [7:0] d; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_uart_sched_if #(.ADR_W(ADR_W)) wbm ();

  logic [N_REQ-1:0]   req_valid = '0;
  logic [8*N_REQ-1:0] req_data  = '0;
  logic [N_REQ-1:0]   req_last  = '0;
  logic [N_REQ-1:0]   req_ready;
  logic               rx_valid;
  logic [7:0]         rx_data;
  logic               rx_ready = 1'b0;
  logic               rx_en    = 1'b0;
  logic               busy;

  wb_uart_sched #(
    .N_REQ(N_REQ), .ADR_W(ADR_W), .BASE_ADDR(BASE), .POLL_GAP(POLL_GAP)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbm        (wbm),
    .req_valid_i(req_valid),
    .req_data_i (req_data),
    .req_last_i (req_last),
    .req_ready_o(req_ready),
    .rx_valid_o (rx_valid),
    .rx_data_o  (rx_data),
    .rx_ready_i (rx_ready),
    .rx_en_i    (rx_en),
    .busy_o     (busy)
  );

  int checks = 0;
  int errors = 0;

  byte_t      fq[N_REQ][$];
  exp_t       exp_tx[$];
  logic [7:0] exp_rx[$];
  logic [7:0] rx_fifo[$];
  int         ready_cnt[N_REQ];

  bit tx_full = 0, hold_wr = 0, gap_chk_en = 0, rx_rand = 0;
  bit cap_first = 0, got_first = 0;
  int gap_seen = 0;
  logic [31:0] first_adr = '0;
  logic        first_we  = 1'b0;

  bit          ack_r = 0, in_cyc = 0, last_tx_empty = 0, wr_ack = 0;
  int          lat = 0, idle_run = 0;
  logic [31:0] t_adr = '0, t_dat = '0, rd_dat = '0;
  logic        t_we = 1'b0;
  logic [7:0]  exp_r = '0;
  logic [N_REQ-1:0] pop_pend = '0;
  exp_t        e;

  assign wbm.wbm_ack_i = ack_r;
  assign wbm.wbm_dat_i = rd_dat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // feeders, RX sink and wb_uart slave model, all acting on the falling edge
  always @(negedge clk) begin
    wr_ack = 0;
    for (int k = 0; k < N_REQ; k++) if (pop_pend[k]) void'(fq[k].pop_front());
    pop_pend = '0;
    for (int k = 0; k < N_REQ; k++) begin
      req_valid[k]       = (fq[k].size() != 0);
      req_data[8*k +: 8] = req_valid[k] ? fq[k][0].d : 8'h00;
      req_last[k]        = req_valid[k] ? fq[k][0].l : 1'b0;
    end
    if (rx_rand) rx_ready = ($urandom_range(0, 3) != 0);
    if (rx_valid && rx_ready) begin
      if (exp_rx.size() == 0) chk("rx_unexpected", exp_rx.size(), 1);
      else chk("rx_data", {24'h0, rx_data}, {24'h0, exp_rx.pop_front()});
    end
    if (!wbm.wbm_cyc_o) begin
      idle_run++;
      in_cyc = 0;
    end
    if (ack_r) begin
      ack_r = 0;
      chk("cyc_drop_after_ack", {30'h0, wbm.wbm_cyc_o, wbm.wbm_stb_o}, 0);
    end else if (wbm.wbm_cyc_o && wbm.wbm_stb_o) begin
      if (!in_cyc) begin
        in_cyc = 1;
        t_adr  = wbm.wbm_adr_o;
        t_we   = wbm.wbm_we_o;
        t_dat  = wbm.wbm_dat_o;
        lat    = $urandom_range(0, 2);
        chk("sel", {28'h0, wbm.wbm_sel_o}, 32'hF);
        if (!t_we && (t_adr == BASE + OFF_RX_STATUS || t_adr == BASE + OFF_DATA))
          chk("rx_read_while_full", {31'h0, rx_valid}, 0);
        if (gap_chk_en && last_tx_empty) begin
          chk("poll_gap", {31'h0, idle_run >= POLL_GAP}, 1);
          gap_seen++;
        end
        if (cap_first) begin
          first_adr = t_adr;
          first_we  = t_we;
          cap_first = 0;
          got_first = 1;
        end
        idle_run = 0;
      end else begin
        chk("hold_adr", wbm.wbm_adr_o, t_adr);
        chk("hold_dat", wbm.wbm_dat_o, t_dat);
        chk("hold_we", {31'h0, wbm.wbm_we_o}, {31'h0, t_we});
      end
      if (lat > 0) lat--;
      else if (!(hold_wr && t_we)) begin
        ack_r = 1;
        last_tx_empty = 0;
        rd_dat = '0;
        if (t_we) begin
          chk("wr_adr", t_adr, BASE + OFF_DATA);
          chk("wr_while_full", {31'h0, tx_full}, 0);
          chk("wr_upper", {8'h0, t_dat[31:8]}, 0);
          if (exp_tx.size() == 0) chk("tx_unexpected", exp_tx.size(), 1);
          else begin
            e = exp_tx.pop_front();
            chk("tx_data", {24'h0, t_dat[7:0]}, {24'h0, e.d});
            exp_r  = e.r;
            wr_ack = 1;
          end
        end else if (t_adr == BASE + OFF_TX_STATUS) begin
          rd_dat = {31'h0, !tx_full};
          last_tx_empty = tx_full && !rx_en;
        end else if (t_adr == BASE + OFF_RX_STATUS) begin
          rd_dat = {31'h0, rx_fifo.size() != 0};
        end else begin
          chk("rd_adr", t_adr, BASE + OFF_DATA);
          chk("rx_fifo_nonempty", {31'h0, rx_fifo.size() != 0}, 1);
          if (rx_fifo.size() != 0) rd_dat = {24'h0, rx_fifo.pop_front()};
        end
      end
    end
    #1;
    if (wr_ack) begin
      chk("tx_ready", {30'h0, req_ready}, {30'h0, N_REQ'(1) << exp_r});
      pop_pend = req_ready;
      for (int k = 0; k < N_REQ; k++) ready_cnt[k] += int'(req_ready[k]);
    end
  end

  task automatic push_tx(input int r, input logic [7:0] d, input logic l);
    fq[r].push_back({d, l});
  endtask

  task automatic push_exp(input int r, input logic [7:0] d);
    exp_tx.push_back({8'(r), d});
  endtask

  task automatic wait_tx(input string tag, input int budget);
    for (int i = 0; i < budget && exp_tx.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk(tag, exp_tx.size(), 0);
  endtask

  task automatic wait_rx(input string tag, input int budget);
    for (int i = 0; i < budget && exp_rx.size() != 0; i++) @(posedge clk);
    #1;
    chk(tag, exp_rx.size(), 0);
  endtask

  int r1_before;

  initial begin
    for (int k = 0; k < N_REQ; k++) ready_cnt[k] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc", {31'h0, wbm.wbm_cyc_o}, 0);
    chk("rst_stb", {31'h0, wbm.wbm_stb_o}, 0);
    chk("rst_we", {31'h0, wbm.wbm_we_o}, 0);
    chk("rst_adr", wbm.wbm_adr_o, 0);
    chk("rst_dat", wbm.wbm_dat_o, 0);
    chk("rst_sel", {28'h0, wbm.wbm_sel_o}, 0);
    chk("rst_ready", {30'h0, req_ready}, 0);
    chk("rst_rx_valid", {31'h0, rx_valid}, 0);
    chk("rst_rx_data", {24'h0, rx_data}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    rst = 1'b0;

    // single requester packet, three accept pulses
    r1_before = ready_cnt[1];
    push_tx(1, 8'h55, 0); push_tx(1, 8'hAA, 0); push_tx(1, 8'h0F, 1);
    push_exp(1, 8'h55); push_exp(1, 8'hAA); push_exp(1, 8'h0F);
    wait_tx("t1_drain", 2000);
    chk("t1_ready_pulses", ready_cnt[1] - r1_before, 3);

    // packet lock then round robin hand-off to req1 before req0's next packet
    push_tx(0, 8'h10, 0); push_tx(0, 8'h11, 1); push_tx(0, 8'h12, 1);
    push_tx(1, 8'h20, 1);
    push_exp(0, 8'h10); push_exp(0, 8'h11); push_exp(1, 8'h20); push_exp(0, 8'h12);
    wait_tx("t2_drain", 2000);

    // TX full: only spaced status polls, then everything drains
    tx_full = 1; gap_chk_en = 1;
    for (int i = 0; i < 20; i++) begin
      push_tx(0, 8'(8'h40 + i), i == 19);
      push_exp(0, 8'(8'h40 + i));
    end
    repeat (300) @(posedge clk);
    #1;
    chk("t3_no_writes", exp_tx.size(), 20);
    chk("t3_polls_seen", {31'h0, gap_seen >= 5}, 1);
    tx_full = 0;
    wait_tx("t3_drain", 3000);
    gap_chk_en = 0;

    // RX held while sink stalls, then delivered in order
    rx_en = 1; rx_ready = 0;
    rx_fifo.push_back(8'h3C); rx_fifo.push_back(8'hC3);
    exp_rx.push_back(8'h3C);  exp_rx.push_back(8'hC3);
    for (int i = 0; i < 500 && !rx_valid; i++) @(posedge clk);
    #1;
    chk("t4_valid", {31'h0, rx_valid}, 1);
    chk("t4_data", {24'h0, rx_data}, 32'h3C);
    repeat (2000) @(posedge clk);
    #1;
    chk("t4_valid_held", {31'h0, rx_valid}, 1);
    chk("t4_data_held", {24'h0, rx_data}, 32'h3C);
    chk("t4_no_extra_read", rx_fifo.size(), 1);
    rx_ready = 1;
    wait_rx("t4_drain", 500);

    // concurrent 40-byte TX and RX with a jittery sink
    rx_rand = 1;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      rx_fifo.push_back(b);
      exp_rx.push_back(b);
      push_tx(0, 8'(8'h80 + i), i == 39);
      push_exp(0, 8'(8'h80 + i));
    end
    wait_tx("t5_tx_drain", 6000);
    wait_rx("t5_rx_drain", 3000);
    rx_rand = 0; rx_ready = 1; rx_en = 0;
    repeat (30) @(posedge clk);

    // reset during a stalled DATA write
    hold_wr = 1;
    r1_before = ready_cnt[1];
    push_tx(1, 8'h77, 1);
    push_exp(1, 8'h77);
    for (int i = 0; i < 200 && !(wbm.wbm_cyc_o && wbm.wbm_we_o); i++) @(posedge clk);
    #1;
    chk("t6_write_pending", {31'h0, wbm.wbm_cyc_o && wbm.wbm_we_o}, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_cyc", {31'h0, wbm.wbm_cyc_o}, 0);
    chk("t6_stb", {31'h0, wbm.wbm_stb_o}, 0);
    chk("t6_ready", {30'h0, req_ready}, 0);
    chk("t6_busy", {31'h0, busy}, 0);
    cap_first = 1; hold_wr = 0;
    wait_tx("t6_drain", 2000);
    chk("t6_first_seen", {31'h0, got_first}, 1);
    chk("t6_first_adr", first_adr, BASE + OFF_TX_STATUS);
    chk("t6_first_we", {31'h0, first_we}, 0);
    chk("t6_one_pulse", ready_cnt[1] - r1_before, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_uart_sched.md
Name: wb_uart_sched

Overview:
- Wishbone master that sequences a single wb_uart instance on behalf of N byte-stream requesters.
- Arbitrates TX requesters round-robin with packet locking (grant held until a byte with last=1 is written).
- Interleaves RX polling and delivers received bytes on one valid/ready output stream.
- Sits between on-chip stream sources/sinks (PTP debug, console) and the wb_uart slave port; replaces software polling.

Parameters:
- N_REQ, 2, number of TX requesters (1..8)
- ADR_W, 32, Wishbone address width
- BASE_ADDR, 0, wb_uart base address; registers at BASE+0 DATA, BASE+4 RX_STATUS, BASE+8 TX_STATUS
- POLL_GAP, 16, idle cycles between consecutive status polls when no progress was made (>=1)

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  write enable
- wbm_adr_o  out  ADR_W  address
- wbm_dat_o  out  32  write data, byte in [7:0], [31:8]=0
- wbm_sel_o  out  4  always 4'hF during a cycle
- wbm_dat_i  in  32  read data
- wbm_ack_i  in  1  acknowledge
- req_valid_i  in  N_REQ  per-requester byte valid
- req_data_i  in  8*N_REQ  per-requester byte, requester k at [8k+7:8k]
- req_last_i  in  N_REQ  marks final byte of a packet
- req_ready_o  out  N_REQ  one-hot byte accept pulse
- rx_valid_o  out  1  received byte valid
- rx_data_o  out  8  received byte
- rx_ready_i  in  1  sink accept
- rx_en_i  in  1  enable RX polling
- busy_o  out  1  high whenever FSM is not IDLE

Behaviour:
- Clock and reset: single clock wb_clk_i; reset wb_rst_i is synchronous, active-high.
- Reset values: all wbm_* = 0, req_ready_o = 0, rx_valid_o = 0, rx_data_o = 0, busy_o = 0, grant lock cleared, RR pointer = 0, gap counter = 0, FSM = IDLE.
  - Reset mid-cycle drops cyc/stb on the next edge with no completion; a byte in flight is neither acked to its requester nor retried.
- Bus cycles: classic single transfers. cyc/stb/we/adr/dat are registered and held stable until the cycle in which wbm_ack_i=1. They deassert on the next edge, so there is at least 1 idle cycle between transfers. No timeout.
- FSM states:
  - IDLE -> TX_POLL if any req_valid_i (or lock held with valid); else -> RX_POLL if rx_en_i and !rx_valid_o; else stay.
  - TX_POLL: read TX_STATUS. On ack, bit0=1 -> TX_WR; bit0=0 -> RX_POLL (if enabled and slot free) else GAP.
  - TX_WR: write DATA with the granted requester's data, captured when entering TX_WR. On ack:
    - pulse req_ready_o[g] for exactly 1 cycle;
    - if last=1, release lock and advance RR pointer to g+1 mod N_REQ;
    - -> RX_POLL if enabled and slot free, else IDLE.
  - RX_POLL: read RX_STATUS. On ack, bit0=1 -> RX_RD; else -> GAP if no TX byte was written this round, else IDLE.
  - RX_RD: read DATA. On ack, latch [7:0] into rx_data_o, set rx_valid_o, -> IDLE.
  - GAP: count POLL_GAP cycles -> IDLE.
- Arbitration: evaluated only when unlocked and entering TX_POLL. Search starts at the RR pointer; the first requester with valid=1 wins and the lock is set. While locked, other requesters are ignored even if the granted one drops valid; the FSM waits in IDLE/RX polling.
- Simultaneous TX and RX work: TX has priority each round; one RX poll follows each TX attempt, so RX is never starved.
- RX output: single holding register; no RX poll while rx_valid_o=1. It clears when rx_valid_o && rx_ready_i. If rx_en_i deasserts, a pending byte stays valid.
- Requesters must hold valid/data/last stable until ready. Changed data after capture is not observed.

Decomposition:
- Package wb_uart_pkg: register offsets (DATA=0, RX_STATUS=4, TX_STATUS=8), status bit index 0, FSM state enum.
- Sub-module wb_uart_rr_arb: N_REQ round-robin arbiter with lock/advance inputs and one-hot grant plus index outputs.

Test Plan:
- Single requester, N_REQ=2, 3 bytes 0x55,0xAA,0x0F (last on 3rd), loop to wb_uart + uart_model at 115200 -> model receives 55 AA 0F in order; 3 ready pulses.
- Both requesters valid: req0 sends packet 0x10,0x11(last), req1 sends 0x20(last) -> wire order 10 11 20; next round starts at req1.
- TX FIFO full (TX_STATUS bit0=0), 20 bytes queued at 19200 baud -> no DATA writes while status=0; status polls separated by >= POLL_GAP idle cycles; all 20 bytes delivered.
- uart_model sends 0x3C,0xC3 while rx_ready_i is held low for 5000 cycles -> rx_valid_o=1 with 0x3C held; no RX reads issued; after release, 0x3C then 0xC3.
- Concurrent: 40-byte TX from req0 while model sends 40 bytes at 57600 -> both streams match, no RX overrun.
- Assert wb_rst_i for 1 cycle during a TX_WR with ack withheld -> next cycle cyc=stb=0, no ready pulse; after reset, first bus op is a TX_STATUS read.
